// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   XLEN / MASK_W   : word width and byte-lane count
//   ADDR_LSB        : byte-offset bits in a word address
//   merge()         : byte-lane write merge
//   in_range()      : word-offset range check against the array depth
package dmem_pkg;

  localparam int XLEN     = 32;
  localparam int MASK_W   = XLEN / 8;
  localparam int ADDR_LSB = 2;

  // Replace the bytes of old_w selected by mask with the same bytes of new_w.
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0]   old_w,
                                            input logic [XLEN-1:0]   new_w,
                                            input logic [MASK_W-1:0] mask);
    logic [XLEN-1:0] w;
    w = old_w;
    for (int k = 0; k < MASK_W; k++)
      if (mask[k]) w[8*k +: 8] = new_w[8*k +: 8];
    return w;
  endfunction

  // off is (addr - base); anything below base wraps to a huge offset and
  // therefore fails the same comparison as anything past the top.
  function automatic logic in_range(input logic [XLEN-1:0] off,
                                    input int unsigned      depth);
    return 32'(off >> ADDR_LSB) < depth;
  endfunction

endpackage

// File: rtl/dmem_lat_pipe.sv
// dmem_lat_pipe: LAT-deep response pipe carrying {vld, err, data}.
//   i_clk, i_rst     : clock, synchronous active-high flush
//   i_vld/i_err/i_data : response slot entering stage 0
//   o_vld/o_err/o_data : response slot leaving the last stage
// Data registers only load behind a valid slot, so o_data holds the last
// returned word between reads.
module dmem_lat_pipe
  import dmem_pkg::*;
#(
  parameter int LAT = 1,
  parameter int W   = XLEN
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  input  logic         i_err,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic         o_err,
  output logic [W-1:0] o_data
);

  logic [LAT-1:0]        vld_pipe;
  logic [LAT-1:0]        err_pipe;
  logic [LAT-1:0][W-1:0] dat_pipe;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= i_vld;
      err_pipe[0] <= i_err;
      if (i_vld) dat_pipe[0] <= i_data;
      for (int k = 1; k < LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign o_vld  = vld_pipe[LAT-1];
  assign o_err  = err_pipe[LAT-1];
  assign o_data = dat_pipe[LAT-1];

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: memory-side responder for the pipeline dmem request interface.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_dmem_addr       : request byte address
//   i_dmem_wdata/mask : lane-aligned write data and byte enables
//   i_dmem_wen/ren    : write / read request this cycle
//   o_dmem_rdata      : read word, held between responses
//   o_dmem_rvld       : read response strobe, RD_LAT cycles after the request
//   o_dmem_err        : misaligned / out-of-range strobe in the response slot
// One request per cycle, no stalls. Same-word read+write is read-before-write.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int              RD_LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_dmem_addr,
  input  logic [XLEN-1:0]   i_dmem_wdata,
  input  logic [MASK_W-1:0] i_dmem_mask,
  input  logic              i_dmem_wen,
  input  logic              i_dmem_ren,
  output logic [XLEN-1:0]   o_dmem_rdata,
  output logic              o_dmem_rvld,
  output logic              o_dmem_err
);

  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("dmem_resp: RD_LAT must be in 1..4");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dmem_resp: DEPTH must be a power of two >= 4");
    end
    if ((BASE_ADDR & XLEN'(DEPTH * 4 - 1)) != 0) begin : g_bad_base
      $error("dmem_resp: BASE_ADDR must be aligned to DEPTH*4");
    end
  endgenerate

  logic [XLEN-1:0]  mem [DEPTH];

  logic [XLEN-1:0]  off;
  logic [IDX_W-1:0] idx;
  logic             misal;
  logic             bad;
  logic [XLEN-1:0]  rd_word;

  assign off   = i_dmem_addr - BASE_ADDR;
  assign idx   = off[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign misal = |i_dmem_addr[ADDR_LSB-1:0];
  assign bad   = (i_dmem_ren | i_dmem_wen) & (misal | !in_range(off, DEPTH));

  // Array is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_dmem_wen && !bad)
      mem[idx] <= merge(mem[idx], i_dmem_wdata, i_dmem_mask);
  end

  // Sampled into stage 0 on the same edge as the write, so a same-word
  // write lands after the old word has been captured.
  assign rd_word = bad ? '0 : mem[idx];

  dmem_lat_pipe #(
    .LAT (RD_LAT),
    .W   (XLEN)
  ) u_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (i_dmem_ren),
    .i_err  (bad),
    .i_data (rd_word),
    .o_vld  (o_dmem_rvld),
    .o_err  (o_dmem_err),
    .o_data (o_dmem_rdata)
  );

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed + random checks of dmem_resp against a byte-array
// memory model and a ring of expected response slots.
module tb_dmem_resp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          LAT   = 3;
  localparam int          RING  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        rvld;
  logic        err;

  always #5 clk = ~clk;

  dmem_resp #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .RD_LAT    (LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dmem_addr  (addr),
    .i_dmem_wdata (wdata),
    .i_dmem_mask  (mask),
    .i_dmem_wen   (wen),
    .i_dmem_ren   (ren),
    .o_dmem_rdata (rdata),
    .o_dmem_rvld  (rvld),
    .o_dmem_err   (err)
  );

  // Reference: memory as bytes, responses as slots keyed by cycle number.
  logic [7:0]  ref_mem [DEPTH*4];
  bit          e_vld [RING];
  bit          e_err [RING];
  logic [31:0] e_dat [RING];
  logic [31:0] hold = '0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int o;
    o = int'(a - BASE);
    return {ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < RING; i++) begin
      e_vld[i] = 1'b0;
      e_err[i] = 1'b0;
      e_dat[i] = '0;
    end
  endtask

  // One cycle: present a request, advance the model, clock, check outputs.
  task automatic step(input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m, input bit rs);
    bit bad;
    int s;
    ren = r; wen = w; addr = a; wdata = d; mask = m; rst = rs;
    bad = (r || w) && (a[1:0] != 2'b00 || longint'(a) < longint'(BASE) ||
                       longint'(a) >= longint'(BASE) + DEPTH * 4);
    if (rs) clear_slots();
    else begin
      s = (cyc + LAT) % RING;
      if (r) begin
        e_vld[s] = 1'b1;
        e_dat[s] = bad ? 32'h0 : ref_rd(a);
      end
      if (bad) e_err[s] = 1'b1;
      if (w && !bad)
        for (int k = 0; k < 4; k++)
          if (m[k]) ref_mem[int'(a - BASE) + k] = d[8*k +: 8];
    end
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % RING;
    if (rs) hold = '0;
    else if (e_vld[s]) hold = e_dat[s];
    chk("rvld",  {31'b0, rvld}, {31'b0, e_vld[s]});
    chk("err",   {31'b0, err},  {31'b0, e_err[s]});
    chk("rdata", rdata, hold);
    e_vld[s] = 1'b0;
    e_err[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    step(1'b0, 1'b1, a, d, m, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    clear_slots();

    // reset
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    // preload every word so all later reads are defined
    for (int i = 0; i < DEPTH; i++) wr(BASE + 32'(i * 4), $urandom, 4'hF);
    idle(LAT);

    // full write then read
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);
    idle(LAT);

    // partial write
    wr(32'h14, 32'h11223344, 4'hF);
    wr(32'h14, 32'h0000AA00, 4'b0010);
    rd(32'h14);
    idle(LAT);

    // same-cycle read+write: old data, then new
    wr(32'h20, 32'h5, 4'hF);
    step(1'b1, 1'b1, 32'h20, 32'h9, 4'hF, 1'b0);
    rd(32'h20);
    idle(LAT);

    // mask 0 write is a silent no-op
    wr(32'h18, 32'hFFFF_FFFF, 4'h0);
    rd(32'h18);
    idle(LAT);

    // errors: misaligned read, out-of-range write/read, last word intact
    rd(32'h13);
    idle(LAT);
    wr(BASE + DEPTH * 4, 32'hCAFEF00D, 4'hF);
    rd(BASE + DEPTH * 4 + 4);
    rd(BASE + DEPTH * 4 - 4);
    wr(32'hFFFF_FFFC, 32'h1, 4'hF);
    idle(LAT);

    // back-to-back reads
    rd(32'h0);
    rd(32'h4);
    rd(32'h8);
    idle(LAT);

    // reset with a read in flight; array must survive
    rd(32'h10);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    idle(LAT + 1);
    rd(32'h10);
    idle(LAT);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 1)
        a = BASE + DEPTH * 4 + 32'($urandom_range(0, 63) * 4);
      else
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      step(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom), 1'b0);
    end
    idle(LAT + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the memory-side end of the pipeline's dmem request interface.
- Accepts one word-aligned request per cycle from the memory stage (address, write data, byte mask, read/write enables) and performs byte-masked writes into a local word array.
- Returns full-word read data after a fixed, parameterised latency.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- RD_LAT, 1, read latency in cycles; legal range 1..4.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_dmem_addr  in  32  byte address of the request; word-aligned by the requester
- i_dmem_wdata  in  32  write data, already lane-aligned
- i_dmem_mask  in  4  byte-lane enables; bit k selects wdata[8k+7:8k]
- i_dmem_wen  in  1  write request this cycle
- i_dmem_ren  in  1  read request this cycle
- o_dmem_rdata  out  32  read word, valid when o_dmem_rvld is high
- o_dmem_rvld  out  1  read response strobe, RD_LAT cycles after the read request
- o_dmem_err  out  1  error strobe, aligned with the response slot of the erroneous request

Behaviour:
- Reset: i_rst is synchronous and active-high; clock is i_clk.
  - o_dmem_rdata=0, o_dmem_rvld=0, o_dmem_err=0.
  - All latency-pipe stages are cleared, so in-flight reads are dropped: no rvld pulse appears for a request issued before or during reset.
  - Array contents are not reset.
- Index and range checks:
  - idx = (addr - BASE_ADDR) >> 2.
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*4.
  - Misaligned iff addr[1:0] ≠ 0.
  - bad = (ren | wen) & (misaligned | !in_range).
- Write:
  - On the clock edge with wen & !bad, mem[idx] byte k ← wdata byte k for each set mask bit; other bytes are unchanged.
  - mask = 0 is a legal no-op with no error.
  - When bad, the write is dropped.
- Read:
  - Stage 0 captures the array word at the edge of the request cycle. When bad, it captures 0 instead.
  - The word then propagates through RD_LAT-1 further registers.
  - o_dmem_rdata updates only when a valid read emerges and holds its last value otherwise.
  - The mask is ignored on reads; the full word is always returned.
- Simultaneous ren & wen to the same word: read-before-write. The read returns the old contents, and the write is committed the same edge.
- Write at cycle N, read of the same word at N+1: the read returns the new data. No bypass logic is needed because the array is already updated.
- Throughput: a new request is accepted every cycle with no stall.
  - Back-to-back reads produce back-to-back rvld pulses, in order.
- Error timing:
  - o_dmem_err pulses for one cycle, RD_LAT cycles after a bad request, whether read or write.
  - For a bad read, rvld also pulses in that cycle, with rdata = 0.
- Neither ren nor wen asserted: no state change; rvld=0 and err=0 in the corresponding response slot.
- RD_LAT outside 1..4 is an elaboration error (generate-time check).

Decomposition:
- dmem_pkg holds:
  - XLEN=32 and MASK_W=4.
  - The byte-lane merge function: merge(old, new, mask) → word.
  - The range-check constants.
- Sub-module dmem_lat_pipe: an RD_LAT-deep shift register carrying {vld, err, data}, with synchronous flush on i_rst.
- The top level holds the array, the index/range logic and the write merge.

Test Plan:
- Reset, then write addr 0x10, wdata 0xDEADBEEF, mask 4'hF; read 0x10 at the next cycle → rvld exactly RD_LAT cycles later with rdata 0xDEADBEEF, err 0.
- Partial write: preload 0x11223344, write wdata 0x0000AA00 with mask 4'b0010, then read → 0x1122AA44.
- Same-cycle ren & wen to 0x20 (old value 0x5, new value 0x9) → read returns 0x5; a following read returns 0x9.
- Errors:
  - Read at 0x13 (misaligned) → rvld=1, err=1, rdata=0.
  - Write at BASE_ADDR+DEPTH*4 → err=1, and the array is unchanged (verify by reading the last word).
- Pipelined reads: RD_LAT=3, reads of 0x0, 0x4, 0x8 on consecutive cycles → three consecutive rvld pulses with matching data, in order.
- Reset mid-flight: RD_LAT=3, read issued, i_rst asserted one cycle later → no rvld pulse; outputs are 0 after reset; array data is preserved.
